// File: rtl/bank_arbiter_pkg.sv
// Shared types and sizing helpers for the CoCo/Arduino EEPROM bus arbiter.
package bank_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COCO,
        DRAIN,
        TURN,
        ARD,
        BACK
    } arb_state_e;

    localparam int GRANT_TIMEOUT_DFLT = 4096;
    localparam int WDOG_W = $clog2(GRANT_TIMEOUT_DFLT);

    // Watchdog width for an arbitrary timeout; never narrower than one bit.
    function automatic int wdog_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/bank_arbiter_sync_bus.sv
// Multi-bit synchroniser: every bit of d passes STAGES flops before use.
module sync_bus
    import bank_arbiter_pkg::*;
#(
    parameter int              WIDTH   = 1,
    parameter int              STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    // NOTE: the flop chain is a small array of real registers, so it is reset
    // explicitly to the inactive level of each input; nothing reads garbage after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= RST_VAL;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/bank_arbiter.sv
// EEPROM bus arbiter between the CoCo cartridge port and the Arduino, with bank register and grant watchdog.
// Optional LED pulse stretching is enabled by defining LED_STRETCH_EN.
module bank_arbiter
    import bank_arbiter_pkg::*;
#(
    parameter int BANK_BITS     = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int GRANT_TIMEOUT = 4096,
    parameter int LED_STRETCH_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 c_power,
    input  logic                 a_power,
    input  logic                 eclk,
    input  logic                 scs,
    input  logic                 cts,
    input  logic                 coco_rw,
    input  logic [BANK_BITS-1:0] coco_addr,
    input  logic                 busreq,
    input  logic [BANK_BITS-1:0] banksw,
    input  logic                 ard_een,
    input  logic                 ard_we,
    output logic                 ard_grant,
    output logic                 ard_sel,
    output logic                 timeout,
    output logic                 c_busen,
    output logic                 c_dataen,
    output logic                 a_busen,
    output logic [BANK_BITS-1:0] bank,
    output logic                 een,
    output logic                 wee,
    output logic                 led_cbus,
    output logic                 led_scs,
    output logic                 led_cts,
    output logic                 led_rw
);

    localparam int CW = wdog_width(GRANT_TIMEOUT);
    localparam int SW = 7 + 2 * BANK_BITS;
    // Idle levels: powers/eclk/busreq low, active-low strobes high, read selected.
    localparam logic [SW-1:0] SYNC_RST = {7'b0001110, {(2 * BANK_BITS){1'b0}}};

    logic                 c_power_s, a_power_s, eclk_s, scs_s, cts_s, coco_rw_s, busreq_s;
    logic [BANK_BITS-1:0] coco_addr_s, banksw_s;

    sync_bus #(
        .WIDTH  (SW),
        .STAGES (SYNC_STAGES),
        .RST_VAL(SYNC_RST)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({c_power, a_power, eclk, scs, cts, coco_rw, busreq, coco_addr, banksw}),
        .q    ({c_power_s, a_power_s, eclk_s, scs_s, cts_s, coco_rw_s, busreq_s, coco_addr_s, banksw_s})
    );

    arb_state_e           state, state_nxt;
    logic [CW-1:0]        wdog;
    logic                 wdog_exp;
    logic                 scs_d;
    logic                 timeout_nxt;
    logic [BANK_BITS-1:0] coco_bank, coco_bank_nxt;
    logic                 coco_side;

    assign wdog_exp = (wdog == CW'(GRANT_TIMEOUT - 1));

    // NOTE: every variable is given a default before the case so no path
    // leaves one unassigned; that keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (c_power_s)                   state_nxt = COCO;
                else if (a_power_s && busreq_s)  state_nxt = ARD;
            end
            COCO: begin
                if (!c_power_s)                  state_nxt = IDLE;
                else if (busreq_s && a_power_s)  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!c_power_s)                  state_nxt = IDLE;
                else if (!a_power_s)             state_nxt = COCO;
                else if (scs_s && cts_s && !eclk_s) state_nxt = TURN;
            end
            TURN: state_nxt = c_power_s ? ARD : IDLE;
            ARD: begin
                // Losing c_power alone does not revoke an active, wanted grant.
                if (!busreq_s || !a_power_s || wdog_exp)
                    state_nxt = c_power_s ? BACK : IDLE;
            end
            BACK:    state_nxt = c_power_s ? COCO : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        timeout_nxt   = timeout;
        coco_bank_nxt = coco_bank;
        if (state == ARD && wdog_exp)
            timeout_nxt = 1'b1;
        else if ((state == COCO || state == IDLE) && !busreq_s)
            timeout_nxt = 1'b0;
        if (state == COCO && scs_d && !scs_s)
            coco_bank_nxt = coco_addr_s;
    end

    assign coco_side = (state_nxt == COCO) || (state_nxt == DRAIN);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wdog      <= '0;
            scs_d     <= 1'b1;
            timeout   <= 1'b0;
            coco_bank <= '0;
            ard_grant <= 1'b0;
            ard_sel   <= 1'b0;
            c_busen   <= 1'b1;
            c_dataen  <= 1'b1;
            a_busen   <= 1'b1;
            bank      <= '0;
        end else begin
            state     <= state_nxt;
            wdog      <= (state == ARD && state_nxt == ARD) ? wdog + CW'(1) : '0;
            scs_d     <= scs_s;
            timeout   <= timeout_nxt;
            coco_bank <= coco_bank_nxt;
            ard_grant <= (state_nxt == ARD);
            ard_sel   <= a_power_s && c_power_s && !scs_s && eclk_s;
            c_busen   <= !coco_side;
            c_dataen  <= coco_side ? (scs_s && cts_s) : 1'b1;
            a_busen   <= (state_nxt != ARD);
            bank      <= (state_nxt == ARD) ? banksw_s : coco_bank_nxt;
        end
    end

    // EEPROM strobes follow the current owner; the CoCo side never writes.
    always_comb begin
        een = 1'b1;
        wee = 1'b1;
        if (state == ARD) begin
            een = ard_een;
            if (a_power_s) wee = ard_we;
        end else if (state == COCO) begin
            een = cts_s;
        end
    end

    logic [3:0] led_ev, led_q;
    assign led_ev = {!c_busen, !scs_s, !cts_s, !wee};

`ifdef LED_STRETCH_EN
    logic [LED_STRETCH_W-1:0] led_cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) led_cnt[i] <= '0;
            led_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (led_ev[i])
                    led_cnt[i] <= '1;
                else if (led_cnt[i] != '0)
                    led_cnt[i] <= led_cnt[i] - 1'b1;
                led_q[i] <= led_ev[i] || (led_cnt[i] != '0);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= '0;
        else        led_q <= led_ev;
    end
`endif

    assign {led_cbus, led_scs, led_cts, led_rw} = led_q;

    // CoCo R/W is carried through the synchroniser but no decision depends on it.
    logic unused_ok;
    assign unused_ok = &{1'b0, coco_rw_s, (LED_STRETCH_W > 0)};

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed scenarios plus a randomized grant scoreboard for bank_arbiter.
module tb_bank_arbiter;

    localparam int T  = 8;
    localparam int BB = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_power, a_power, eclk, scs, cts, coco_rw, busreq, ard_een, ard_we;
    logic [BB-1:0] coco_addr, banksw, bank;
    logic          ard_grant, ard_sel, timeout, c_busen, c_dataen, a_busen, een, wee;
    logic          led_cbus, led_scs, led_cts, led_rw;

    bank_arbiter #(
        .BANK_BITS    (BB),
        .SYNC_STAGES  (2),
        .GRANT_TIMEOUT(T),
        .LED_STRETCH_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .c_power(c_power), .a_power(a_power), .eclk(eclk),
        .scs(scs), .cts(cts), .coco_rw(coco_rw), .coco_addr(coco_addr), .busreq(busreq),
        .banksw(banksw), .ard_een(ard_een), .ard_we(ard_we), .ard_grant(ard_grant),
        .ard_sel(ard_sel), .timeout(timeout), .c_busen(c_busen), .c_dataen(c_dataen),
        .a_busen(a_busen), .bank(bank), .een(een), .wee(wee), .led_cbus(led_cbus),
        .led_scs(led_scs), .led_cts(led_cts), .led_rw(led_rw)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    logic rand_eclk = 1'b0;

    typedef struct {
        logic [BB-1:0] on_bank;
        logic [BB-1:0] off_bank;
        int            width;
        logic          tmo;
    } exp_t;

    exp_t sb[$];
    exp_t e_push, e_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_eclk) eclk = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_grant(input logic lvl, input int budget, input string name);
        int k = 0;
        while (ard_grant !== lvl && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (ard_grant !== lvl) begin
            n_bad++;
            $display("FAIL %s: ard_grant=%b after %0d clks, expected %b", name, ard_grant, k, lvl);
        end
    endtask

    // Monitor: every grant pulse is matched against the oldest expected transaction.
    logic mon_en = 1'b0;
    logic grant_prev = 1'b0;
    int   gw = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ard_grant && !grant_prev) begin
                gw = 1;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_grant: got grant, expected none queued");
                end else begin
                    check("bank_at_grant", 32'(bank), 32'(sb[0].on_bank));
                end
            end else if (ard_grant) begin
                gw++;
            end else if (grant_prev && sb.size() != 0) begin
                e_pop = sb.pop_front();
                check("grant_width", gw, e_pop.width);
                check("bank_after_release", 32'(bank), 32'(e_pop.off_bank));
                check("timeout_at_release", 32'(timeout), 32'(e_pop.tmo));
            end
        end
        grant_prev = ard_grant;
    end

    initial begin
        int            early, turn_n, seen, w, gcnt, saw_coco, led_n, n;
        logic [BB-1:0] last_coco, addr, bsw;

        c_power = 0; a_power = 0; eclk = 0; scs = 1; cts = 1; coco_rw = 1;
        coco_addr = '0; busreq = 0; banksw = '0; ard_een = 1; ard_we = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;

        check("rst_c_busen",  32'(c_busen), 1);
        check("rst_c_dataen", 32'(c_dataen), 1);
        check("rst_a_busen",  32'(a_busen), 1);
        check("rst_grant",    32'(ard_grant), 0);
        check("rst_sel",      32'(ard_sel), 0);
        check("rst_timeout",  32'(timeout), 0);
        check("rst_bank",     32'(bank), 0);
        check("rst_een_wee",  32'({een, wee}), 32'h3);
        check("rst_leds",     32'({led_cbus, led_scs, led_cts, led_rw}), 0);

        // CoCo takes the bus after the synchroniser delay plus one clock.
        c_power = 1; a_power = 1; rst_n = 1;
        repeat (3) tick();
        check("coco_c_busen", 32'(c_busen), 0);
        check("coco_grant",   32'(ard_grant), 0);

        // Arduino request during an active SCS cycle must wait for it to end.
        coco_addr = 2'b01; scs = 0; eclk = 1; busreq = 1; banksw = 2'b11;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ard_grant) early = 1;
        end
        check("grant_waits_for_scs", early, 0);
        check("drain_c_busen",       32'(c_busen), 0);
        check("ard_sel_active",      32'(ard_sel), 1);
        scs = 1; eclk = 0;
        turn_n = 0; seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (ard_grant) seen = 1;
            else if (c_busen && a_busen) turn_n++;
        end
        check("grant_after_drain", seen, 1);
        check("turn_cycles",       turn_n, 1);
        check("bank_arduino",      32'(bank), 3);
        ard_een = 0; ard_we = 0;
        #1;
        check("een_follows_ard", 32'(een), 0);
        check("wee_follows_ard", 32'(wee), 0);
        ard_een = 1; ard_we = 1;
        busreq = 0;
        wait_grant(0, 10, "release_on_busreq_low");
        check("bank_reverts", 32'(bank), 1);
        check("no_timeout",   32'(timeout), 0);
        repeat (4) tick();

        // Watchdog: a held request is revoked after T granted cycles.
        busreq = 1;
        wait_grant(1, 40, "grant_for_watchdog");
        w = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!ard_grant) break;
            w++;
        end
        check("watchdog_width", w, T);
        check("timeout_set",    32'(timeout), 1);
        // busreq was still high on return to COCO, so a drained request completes with a 1-cycle grant.
        busreq = 0;
        gcnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ard_grant) gcnt++;
        end
        check("drained_grant_width", gcnt, 1);
        check("timeout_cleared",     32'(timeout), 0);

        // Asynchronous reset in the middle of a grant.
        busreq = 1; ard_we = 0;
        wait_grant(1, 40, "grant_before_reset");
        #3 rst_n = 0;
        #1;
        check("async_rst_grant", 32'(ard_grant), 0);
        check("async_rst_wee",   32'(wee), 1);
        c_power = 0; a_power = 1; busreq = 1; ard_we = 1;
        #2 rst_n = 1;
        saw_coco = 0; seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (!c_busen) saw_coco = 1;
            if (ard_grant) seen = 1;
        end
        check("idle_to_ard_grant",    seen, 1);
        check("idle_to_ard_no_coco",  saw_coco, 0);
        busreq = 0;
        wait_grant(0, 10, "release_from_idle_grant");
        repeat (4) tick();

        // One-clock SCS pulse on the activity LED.
        scs = 0;
        tick();
        scs = 1;
        led_n = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (led_scs) led_n++;
        end
`ifdef LED_STRETCH_EN
        check("led_scs_stretch", led_n, 16);
`else
        check("led_scs_pulse", led_n, 1);
`endif

        // Randomized phase: CoCo accesses and Arduino grants of random length.
        rst_n = 0;
        tick();
        c_power = 1; a_power = 1; busreq = 0; scs = 1; cts = 1;
        rst_n = 1;
        repeat (6) tick();
        last_coco = '0;
        rand_eclk = 1'b1;
        mon_en = 1'b1;
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                addr = BB'($urandom_range(0, 3));
                coco_addr = addr;
                scs = 0;
                repeat (3) tick();
                scs = 1;
                repeat (3) tick();
                last_coco = addr;
            end
            bsw = BB'($urandom_range(0, 3));
            n = int'($urandom_range(0, T - 1));
            // Request drop is seen two syncs plus one decision cycle later; watchdog caps at T.
            e_push.on_bank  = bsw;
            e_push.off_bank = last_coco;
            e_push.width    = (n + 3 < T) ? n + 3 : T;
            e_push.tmo      = (n + 3 >= T);
            sb.push_back(e_push);
            banksw = bsw;
            busreq = 1;
            wait_grant(1, 40, "grant_rand");
            repeat (n) tick();
            busreq = 0;
            wait_grant(0, 20, "release_rand");
            repeat (6) tick();
        end
        mon_en = 1'b0;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
